rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Parametrised RV decode stage between fetch and execute.
- Replaces a fixed 64-bit, always-advancing decode register with three additions:
  - an XLEN-generic immediate path,
  - a valid/ready handshake with a 2-entry skid buffer,
  - flush support, an illegal-instruction flag and an encoded return-address-stack (RAS) hint.
- Output is a registered decoded bundle consumed by the execute stage.

Parameters:
- XLEN, 64, datapath width (32 or 64); sets immediate, PC width and W-op legality.
- RESET_PC, 'h80000000, value of out_pc while reset is asserted and after reset.
- SKID_EN, 1, 1 = 2-entry skid buffer (full throughput); 0 = single register, in_ready = ~out_valid | out_ready.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  fetch holds an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  XLEN  PC of the incoming instruction.
- in_inst  in  32  incoming instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_inst  out  32  raw instruction word.
- out_rd, out_rs1, out_rs2  out  5 each  = inst[11:7], inst[19:15], inst[24:20].
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  instruction format: 0 N, 1 I, 2 U, 3 S, 4 J, 5 R, 6 B.
- out_cls  out  12  one-hot class: imm, ld, st, imm32, sys, auipc, lui, op, op32, br, jal, jalr.
- out_func3  out  3  = inst[14:12].
- out_w  out  1  op32 or imm32.
- out_mul  out  1  R-format & inst[25] & ~inst[14].
- out_div  out  1  R-format & inst[25] & inst[14].
- out_rem  out  1  out_div & inst[13].
- out_dsign  out  1  R-format & inst[25] & ~inst[12].
- out_ras  out  2  RAS hint: 00 none, 01 call, 10 ret, 11 ret_call.
- out_illegal  out  1  undecodable instruction.

Behaviour:
- Reset:
  - out_valid=0 and skid empty.
  - out_pc=RESET_PC.
  - All other outputs 0, including out_fmt=0 (N).
  - in_ready=1 from the cycle after reset is released.
- Decode is combinational on in_inst and is registered on acceptance (in_valid & in_ready); latency is 1 cycle.
- Immediates are built from the standard I/U/S/J/B field placements and sign-extended from bit 31 to XLEN:
  - U-format: {inst[31:12], 12'b0}, then sign-extended.
  - R-format and N-format: imm = 0.
- RAS hint uses link = (x1 or x5):
  - call: jal with rd=link; or jalr with rd=link and rs1 not link; or jalr with rd=link and rs1==rd.
  - ret: jalr with rd not link and rs1=link.
  - ret_call: jalr with rd=link, rs1=link and rs1!=rd.
- out_illegal=1 when any of:
  - inst[1:0] != 2'b11;
  - opcode not in the 12 supported classes;
  - op32 or imm32 with XLEN=32.
  - Illegal bundles still flow through the stage, with out_fmt=N, out_cls=0 and out_imm=0.
- Handshake with SKID_EN=1:
  - in_ready = ~skid_valid (registered; never depends on out_ready combinationally).
  - Accept while out register empty or draining: the bundle loads the out register.
  - Accept while out_valid & ~out_ready: the bundle loads the skid register.
  - out_ready while skid is full: skid moves to the out register; in_ready rises the next cycle.
  - Order is strictly FIFO; bundles are never dropped or duplicated.
  - out_* fields stay stable while out_valid & ~out_ready.
- Flush (highest priority after rst):
  - Next cycle: out_valid=0 and skid empty.
  - An instruction accepted in the same cycle as flush is discarded.
  - out_pc and the other data fields keep stale values; only the valid bits clear.
- Simultaneous events:
  - out_ready and input accepted with skid empty: the new bundle replaces the out register; out_valid stays 1.
  - rst mid-stream: identical to power-up reset; all queued work is lost.

Test Plan:
- XLEN=64: 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, fmt=I, rd=1, rs1=0, imm=0xFFFF_FFFF_FFFF_FFFF, illegal=0.
- 0x800000B7 (lui x1,0x80000) -> imm=0xFFFF_FFFF_8000_0000 with XLEN=64; imm=0x8000_0000 with XLEN=32.
- 0x008000EF (jal ra,+8) -> ras=01, imm=8, fmt=J; 0x00008067 (ret) -> ras=10, fmt=I, rs1=1, rd=0.
- Backpressure: 3 back-to-back instructions, out_ready=0 for 3 cycles -> in_ready=0 after the 2nd is accepted; release gives PCs in order A,B,C; no loss or duplication.
- Out register and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the next instruction emerges 1 cycle after acceptance.
- XLEN=32: 0x0010009B (addiw) and 0x00000000 -> illegal=1, cls=0, imm=0; rst asserted mid-stream -> out_valid=0, out_pc=0x8000_0000.

Source files
------------

// File: rtl/rv_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle.
// Master drives fetch side and execute ready; slave is the stage.
interface rv_decode_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [11:0]     out_cls;
  logic [2:0]      out_func3;
  logic            out_w;
  logic            out_mul;
  logic            out_div;
  logic            out_rem;
  logic            out_dsign;
  logic [1:0]      out_ras;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst,
    input  out_rd, out_rs1, out_rs2, out_imm,
    input  out_fmt, out_cls, out_func3, out_w,
    input  out_mul, out_div, out_rem, out_dsign,
    input  out_ras, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst,
    output out_rd, out_rs1, out_rs2, out_imm,
    output out_fmt, out_cls, out_func3, out_w,
    output out_mul, out_div, out_rem, out_dsign,
    output out_ras, out_illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV decode stage: combinational decode, registered output
// with optional 2-entry skid buffer and flush.
module rv_decode_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h80000000,
  parameter bit              SKID_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  rv_decode_stage_if.slave io
);

  localparam bit X64 = (XLEN == 64);

  typedef enum logic [2:0] {
    F_N, F_I, F_U, F_S, F_J, F_R, F_B
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [11:0]     cls;
    logic            w;
    logic            mul;
    logic            div;
    logic            rem;
    logic            dsign;
    logic [1:0]      ras;
    logic            illegal;
  } dec_t;

  logic [31:0] i;
  logic [4:0]  opc;
  logic        q;
  logic [11:0] cls;
  logic [31:0] imm32;
  logic        lk_rd;
  logic        lk_rs;
  dec_t        d;

  assign i   = io.in_inst;
  assign opc = i[6:2];
  assign q   = (i[1:0] == 2'b11);

  // class bit order: imm ld st imm32 sys auipc lui op op32 br jal jalr
  assign cls[0]  = q & (opc == 5'b00100);
  assign cls[1]  = q & (opc == 5'b00000);
  assign cls[2]  = q & (opc == 5'b01000);
  assign cls[3]  = q & (opc == 5'b00110) & X64;
  assign cls[4]  = q & (opc == 5'b11100);
  assign cls[5]  = q & (opc == 5'b00101);
  assign cls[6]  = q & (opc == 5'b01101);
  assign cls[7]  = q & (opc == 5'b01100);
  assign cls[8]  = q & (opc == 5'b01110) & X64;
  assign cls[9]  = q & (opc == 5'b11000);
  assign cls[10] = q & (opc == 5'b11011);
  assign cls[11] = q & (opc == 5'b11001);

  assign lk_rd = (i[11:7] == 5'd1)
               | (i[11:7] == 5'd5);
  assign lk_rs = (i[19:15] == 5'd1)
               | (i[19:15] == 5'd5);

  always_comb begin
    d       = '0;
    imm32   = '0;
    d.pc    = io.in_pc;
    d.inst  = i;
    d.cls   = cls;
    unique case (1'b1)
      cls[0], cls[1], cls[3],
      cls[4], cls[11]:  d.fmt = F_I;
      cls[5], cls[6]:   d.fmt = F_U;
      cls[2]:           d.fmt = F_S;
      cls[10]:          d.fmt = F_J;
      cls[7], cls[8]:   d.fmt = F_R;
      cls[9]:           d.fmt = F_B;
      default:          d.fmt = F_N;
    endcase
    unique case (d.fmt)
      F_I: imm32 = {{20{i[31]}}, i[31:20]};
      F_U: imm32 = {i[31:12], 12'b0};
      F_S: imm32 = {{20{i[31]}}, i[31:25],
                    i[11:7]};
      F_J: imm32 = {{12{i[31]}}, i[19:12],
                    i[20], i[30:21], 1'b0};
      F_B: imm32 = {{20{i[31]}}, i[7],
                    i[30:25], i[11:8], 1'b0};
      default: imm32 = '0;
    endcase
    d.imm = XLEN'($signed(imm32));
    if (d.fmt == F_R && i[25]) begin
      d.mul   = ~i[14];
      d.div   = i[14];
      d.rem   = i[14] & i[13];
      d.dsign = ~i[12];
    end
    d.w = cls[3] | cls[8];
    // rs1==rd link on jalr is a plain call
    if (cls[10]) d.ras = {1'b0, lk_rd};
    if (cls[11]) d.ras = {lk_rs & ~(lk_rd &
                  (i[19:15] == i[11:7])), lk_rd};
    d.illegal = ~|cls;
  end

  dec_t out_q;
  dec_t skid_q;
  logic ov;
  logic sv;
  logic acc;
  logic drain;

  assign drain = ~ov | io.out_ready;
  assign acc   = io.in_valid & io.in_ready;

  assign io.in_ready = SKID_EN ? ~sv : drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov       <= 1'b0;
      sv       <= 1'b0;
      out_q    <= '0;
      out_q.pc <= RESET_PC;
      skid_q   <= '0;
    end else if (flush) begin
      ov <= 1'b0;
      sv <= 1'b0;
    end else if (drain) begin
      if (sv) begin
        out_q <= skid_q;
        ov    <= 1'b1;
        sv    <= 1'b0;
      end else begin
        ov <= acc;
        if (acc) out_q <= d;
      end
    end else if (acc && SKID_EN) begin
      skid_q <= d;
      sv     <= 1'b1;
    end
  end

  assign io.out_valid   = ov;
  assign io.out_pc      = out_q.pc;
  assign io.out_inst    = out_q.inst;
  assign io.out_rd      = out_q.inst[11:7];
  assign io.out_rs1     = out_q.inst[19:15];
  assign io.out_rs2     = out_q.inst[24:20];
  assign io.out_func3   = out_q.inst[14:12];
  assign io.out_imm     = out_q.imm;
  assign io.out_fmt     = out_q.fmt;
  assign io.out_cls     = out_q.cls;
  assign io.out_w       = out_q.w;
  assign io.out_mul     = out_q.mul;
  assign io.out_div     = out_q.div;
  assign io.out_rem     = out_q.rem;
  assign io.out_dsign   = out_q.dsign;
  assign io.out_ras     = out_q.ras;
  assign io.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: XLEN=64 and XLEN=32 instances
// driven in lockstep against a queue-based reference model.
module tb_rv_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [11:0] cls;
    logic [17:0] rf;
    logic        w;
    logic        mul;
    logic        div;
    logic        rem;
    logic        dsign;
    logic [1:0]  ras;
    logic        ill;
  } bun_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv_decode_stage_if #(.XLEN(64)) b64();
  rv_decode_stage_if #(.XLEN(32)) b32();

  assign b64.in_valid  = iv;
  assign b64.in_pc     = pc;
  assign b64.in_inst   = inst;
  assign b64.out_ready = ordy;
  assign b32.in_valid  = iv;
  assign b32.in_pc     = pc[31:0];
  assign b32.in_inst   = inst;
  assign b32.out_ready = ordy;

  rv_decode_stage #(
    .XLEN(64), .RESET_PC(64'h8000_0000), .SKID_EN(1)
  ) dut64 (.clk(clk), .rst(rst), .flush(flush), .io(b64));

  rv_decode_stage #(
    .XLEN(32), .RESET_PC(32'h8000_0000), .SKID_EN(1)
  ) dut32 (.clk(clk), .rst(rst), .flush(flush), .io(b32));

  bun_t o64, o32;

  always_comb begin
    o64       = '0;
    o64.pc    = b64.out_pc;
    o64.inst  = b64.out_inst;
    o64.imm   = b64.out_imm;
    o64.fmt   = b64.out_fmt;
    o64.cls   = b64.out_cls;
    o64.rf    = {b64.out_rd, b64.out_rs1,
                 b64.out_rs2, b64.out_func3};
    o64.w     = b64.out_w;
    o64.mul   = b64.out_mul;
    o64.div   = b64.out_div;
    o64.rem   = b64.out_rem;
    o64.dsign = b64.out_dsign;
    o64.ras   = b64.out_ras;
    o64.ill   = b64.out_illegal;
  end

  always_comb begin
    o32       = '0;
    o32.pc    = 64'(b32.out_pc);
    o32.inst  = b32.out_inst;
    o32.imm   = 64'(b32.out_imm);
    o32.fmt   = b32.out_fmt;
    o32.cls   = b32.out_cls;
    o32.rf    = {b32.out_rd, b32.out_rs1,
                 b32.out_rs2, b32.out_func3};
    o32.w     = b32.out_w;
    o32.mul   = b32.out_mul;
    o32.div   = b32.out_div;
    o32.rem   = b32.out_rem;
    o32.dsign = b32.out_dsign;
    o32.ras   = b32.out_ras;
    o32.ill   = b32.out_illegal;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic bit lk(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction

  function automatic bun_t ref_dec(input logic [31:0] i,
                                   input logic [63:0] p,
                                   input int xl);
    bun_t   b;
    int     k;
    longint s;
    b      = '0;
    b.pc   = p;
    b.inst = i;
    b.rf   = {i[11:7], i[19:15], i[24:20], i[14:12]};
    s      = longint'($signed(i));
    k      = -1;
    case (i[6:0])
      7'h13: begin k = 0;  b.fmt = 3'd1; end
      7'h03: begin k = 1;  b.fmt = 3'd1; end
      7'h23: begin k = 2;  b.fmt = 3'd3; end
      7'h1b: if (xl == 64) begin k = 3; b.fmt = 3'd1; end
      7'h73: begin k = 4;  b.fmt = 3'd1; end
      7'h17: begin k = 5;  b.fmt = 3'd2; end
      7'h37: begin k = 6;  b.fmt = 3'd2; end
      7'h33: begin k = 7;  b.fmt = 3'd5; end
      7'h3b: if (xl == 64) begin k = 8; b.fmt = 3'd5; end
      7'h63: begin k = 9;  b.fmt = 3'd6; end
      7'h6f: begin k = 10; b.fmt = 3'd4; end
      7'h67: begin k = 11; b.fmt = 3'd1; end
      default: k = -1;
    endcase
    b.ill = (k < 0);
    if (k >= 0) b.cls = 12'(1 << k);
    case (b.fmt)
      3'd1: b.imm = s >>> 20;
      3'd2: b.imm = (s >>> 12) << 12;
      3'd3: b.imm = ((s >>> 25) << 5) | longint'(i[11:7]);
      3'd6: b.imm = ((s >>> 31) << 12)
                  | (longint'(i[7]) << 11)
                  | (longint'(i[30:25]) << 5)
                  | (longint'(i[11:8]) << 1);
      3'd4: b.imm = ((s >>> 31) << 20)
                  | (longint'(i[19:12]) << 12)
                  | (longint'(i[20]) << 11)
                  | (longint'(i[30:21]) << 1);
      default: b.imm = '0;
    endcase
    if (k == 10 && lk(i[11:7])) b.ras = 2'b01;
    if (k == 11) begin
      if (lk(i[11:7]) && lk(i[19:15]) && i[11:7] != i[19:15])
        b.ras = 2'b11;
      else if (lk(i[11:7])) b.ras = 2'b01;
      else if (lk(i[19:15])) b.ras = 2'b10;
    end
    if (b.fmt == 3'd5 && i[25]) begin
      b.mul   = ~i[14];
      b.div   = i[14];
      b.rem   = i[14] & i[13];
      b.dsign = ~i[12];
    end
    b.w = (k == 3 || k == 8);
    return b;
  endfunction

  bun_t q64[$];
  bun_t q32[$];
  bun_t rb;
  bun_t sh64;
  bun_t sh32;

  task automatic model_step();
    bun_t n64, n32;
    bit   a64, a32, p64, p32;
    n64 = ref_dec(inst, pc, 64);
    n32 = ref_dec(inst, {32'd0, pc[31:0]}, 32);
    a64 = iv && q64.size() < 2;
    a32 = iv && q32.size() < 2;
    p64 = ordy && q64.size() > 0;
    p32 = ordy && q32.size() > 0;
    if (rst) begin
      q64.delete(); q32.delete();
      sh64 = rb; sh32 = rb;
    end else if (flush) begin
      q64.delete(); q32.delete();
    end else begin
      if (p64) void'(q64.pop_front());
      if (a64) q64.push_back(n64);
      if (p32) void'(q32.pop_front());
      if (a32) q32.push_back(n32);
    end
    if (q64.size() > 0) sh64 = q64[0];
    if (q32.size() > 0) sh32 = q32[0];
  endtask

  task automatic cmp(input string t, input bun_t o,
                     input bun_t e, input logic ov,
                     input logic ir, input int n,
                     input logic [63:0] m);
    chk({t, ".vld"}, 64'(ov), 64'(n > 0));
    chk({t, ".rdy"}, 64'(ir), 64'(n < 2));
    chk({t, ".pc"}, o.pc & m, e.pc & m);
    chk({t, ".imm"}, o.imm & m, e.imm & m);
    chk({t, ".inst"}, 64'(o.inst), 64'(e.inst));
    chk({t, ".fmt"}, 64'(o.fmt), 64'(e.fmt));
    chk({t, ".cls"}, 64'(o.cls), 64'(e.cls));
    chk({t, ".regs"}, 64'(o.rf), 64'(e.rf));
    chk({t, ".flags"},
        64'({o.w, o.mul, o.div, o.rem, o.dsign, o.ras, o.ill}),
        64'({e.w, e.mul, e.div, e.rem, e.dsign, e.ras, e.ill}));
  endtask

  task automatic cyc(input logic v, input logic [31:0] i,
                     input logic [63:0] p, input logic r,
                     input logic f);
    iv    = v;
    inst  = i;
    pc    = p;
    ordy  = r;
    flush = f;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cmp("d64", o64, sh64, b64.out_valid, b64.in_ready,
        q64.size(), 64'hFFFF_FFFF_FFFF_FFFF);
    cmp("d32", o32, sh32, b32.out_valid, b32.in_ready,
        q32.size(), 64'h0000_0000_FFFF_FFFF);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 15))
      0:  i[6:0] = 7'h13;
      1:  i[6:0] = 7'h03;
      2:  i[6:0] = 7'h23;
      3:  i[6:0] = 7'h1b;
      4:  i[6:0] = 7'h73;
      5:  i[6:0] = 7'h17;
      6:  i[6:0] = 7'h37;
      7:  i[6:0] = 7'h33;
      8:  i[6:0] = 7'h3b;
      9:  i[6:0] = 7'h63;
      10: i[6:0] = 7'h6f;
      11: i[6:0] = 7'h67;
      12: i[6:0] = 7'h67;
      13: i[6:0] = 7'h33;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: i[11:7] = 5'd1;
      1: i[11:7] = 5'd5;
      2: i[11:7] = 5'd0;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: i[19:15] = 5'd1;
      1: i[19:15] = 5'd5;
      2: i[19:15] = i[11:7];
      default: ;
    endcase
    return i;
  endfunction

  initial begin
    rb    = '0;
    rb.pc = 64'h8000_0000;
    sh64  = rb;
    sh32  = rb;
    rst   = 1'b1;
    cyc(0, 32'h0, 64'h0, 0, 0);
    cyc(1, 32'hFFF00093, 64'h40, 1, 0);
    chk("rst.pc64", b64.out_pc, 64'h8000_0000);
    chk("rst.fmt", 64'(b64.out_fmt), 64'd0);
    rst = 1'b0;
    cyc(1, 32'hFFF00093, 64'h1000, 1, 0);
    chk("addi.vld", 64'(b64.out_valid), 64'd1);
    chk("addi.imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi.fmt", 64'(b64.out_fmt), 64'd1);
    chk("addi.rd", 64'(b64.out_rd), 64'd1);
    chk("addi.ill", 64'(b64.out_illegal), 64'd0);
    cyc(1, 32'h800000B7, 64'h1004, 1, 0);
    chk("lui.imm64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui.imm32", 64'(b32.out_imm), 64'h8000_0000);
    cyc(1, 32'h008000EF, 64'h1008, 1, 0);
    chk("jal.ras", 64'(b64.out_ras), 64'd1);
    chk("jal.imm", b64.out_imm, 64'd8);
    chk("jal.fmt", 64'(b64.out_fmt), 64'd4);
    cyc(1, 32'h00008067, 64'h100C, 1, 0);
    chk("ret.ras", 64'(b64.out_ras), 64'd2);
    chk("ret.rs1", 64'(b64.out_rs1), 64'd1);
    chk("ret.rd", 64'(b64.out_rd), 64'd0);
    cyc(0, 32'h0, 64'h0, 1, 0);
    cyc(1, 32'h00000013, 64'hA0, 0, 0);
    cyc(1, 32'h00100093, 64'hB0, 0, 0);
    chk("bp.rdy", 64'(b64.in_ready), 64'd0);
    cyc(1, 32'h00200113, 64'hC0, 0, 0);
    chk("bp.holdA", b64.out_pc, 64'hA0);
    cyc(1, 32'h00200113, 64'hC0, 1, 0);
    chk("bp.B", b64.out_pc, 64'hB0);
    cyc(1, 32'h00200113, 64'hC0, 1, 0);
    chk("bp.C", b64.out_pc, 64'hC0);
    cyc(0, 32'h0, 64'h0, 1, 0);
    chk("bp.empty", 64'(b64.out_valid), 64'd0);
    cyc(1, 32'h00000013, 64'hA4, 0, 0);
    cyc(1, 32'h00100093, 64'hB4, 0, 0);
    cyc(1, 32'h00200113, 64'hC4, 0, 1);
    chk("fl.vld", 64'(b64.out_valid), 64'd0);
    chk("fl.rdy", 64'(b64.in_ready), 64'd1);
    chk("fl.stale", b64.out_pc, 64'hA4);
    cyc(1, 32'h00300193, 64'hD4, 0, 0);
    chk("fl.next", b64.out_pc, 64'hD4);
    cyc(1, 32'h0010009B, 64'h2000, 1, 0);
    chk("addiw.ill32", 64'(b32.out_illegal), 64'd1);
    chk("addiw.cls32", 64'(b32.out_cls), 64'd0);
    chk("addiw.imm32", 64'(b32.out_imm), 64'd0);
    chk("addiw.ill64", 64'(b64.out_illegal), 64'd0);
    cyc(1, 32'h00000000, 64'h2004, 1, 0);
    chk("zero.ill", 64'(b64.out_illegal), 64'd1);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 3) != 0, rnd_inst(),
          {$urandom, $urandom},
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
    cyc(1, 32'h00000013, 64'hE0, 0, 0);
    cyc(1, 32'h00100093, 64'hE4, 0, 0);
    rst = 1'b1;
    cyc(1, 32'h00200113, 64'hE8, 0, 0);
    rst = 1'b0;
    chk("mrst.vld", 64'(b32.out_valid), 64'd0);
    chk("mrst.pc", 64'(b32.out_pc), 64'h8000_0000);
    cyc(0, 32'h0, 64'h0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
